pulp_clock_gate_ctrl: RTL

Control-side counterpart of the asynchronous clock gate. It generates the `en_async` level that drives a synchronizing clock gate in a target domain. A gating request is accepted only after the target has reported idle for a programmable number of consecutive cycles. The block then holds off completion until the gate's synchronizer has settled, so `ack_o` means the clock is really stopped or running.

---
 rtl/pulp_clock_gate_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pulp_clock_gate_ctrl.sv
// Control side of an asynchronous clock gate: produces en_async_o for a downstream synchronizing
// gate. Optional wake-request support is enabled with `define CLK_GATE_CTRL_WAKE_EN.
module pulp_clock_gate_ctrl #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned IDLE_HOLD    = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_en_i,
  input  logic idle_i,
`ifdef CLK_GATE_CTRL_WAKE_EN
  input  logic wake_i,
  input  logic wake_clr_i,
  output logic woke_o,
`endif
  output logic en_async_o,
  output logic ack_o,
  output logic gated_o,
  output logic busy_o
);

  localparam int unsigned Settle  = SYNC_STAGES + GUARD_CYCLES;
  localparam int unsigned SettleW = $clog2(Settle + 1);

  localparam logic [SettleW-1:0] SettleLoad = SettleW'(Settle - 1);
  localparam logic [7:0]         IdleLast   = 8'(IDLE_HOLD - 1);

  localparam logic [2:0] StOn       = 3'd0;
  localparam logic [2:0] StWaitIdle = 3'd1;
  localparam logic [2:0] StGating   = 3'd2;
  localparam logic [2:0] StOff      = 3'd3;
  localparam logic [2:0] StUngating = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [7:0]         idle_cnt_q, idle_cnt_d;
  logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
  logic               req_eff;

`ifdef CLK_GATE_CTRL_WAKE_EN
  logic woke_q, woke_d;

  assign req_eff = req_en_i | wake_i;

  // Set has priority over clear when both land in the same cycle.
  always_comb begin
    woke_d = woke_q;
    if (wake_clr_i) begin
      woke_d = 1'b0;
    end
    if ((state_q == StOff) && wake_i && !req_en_i) begin
      woke_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      woke_q <= 1'b0;
    end else begin
      woke_q <= woke_d;
    end
  end

  assign woke_o = woke_q;
`else
  assign req_eff = req_en_i;
`endif

  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      StOn: begin
        if (!req_eff) begin
          state_d    = StWaitIdle;
          idle_cnt_d = 8'd0;
        end
      end
      StWaitIdle: begin
        if (req_eff) begin
          state_d = StOn;
        end else if (!idle_i) begin
          idle_cnt_d = 8'd0;
        end else if (idle_cnt_q == IdleLast) begin
          state_d      = StGating;
          settle_cnt_d = SettleLoad;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      StGating: begin
        if (settle_cnt_q == '0) begin
          state_d = StOff;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      StOff: begin
        if (req_eff) begin
          state_d      = StUngating;
          settle_cnt_d = SettleLoad;
        end
      end
      StUngating: begin
        if (settle_cnt_q == '0) begin
          state_d = StOn;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      default: state_d = StOn;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StOn;
      idle_cnt_q   <= 8'd0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // en_async_o is a pure state decode, so no input reaches it combinationally.
  always_comb begin
    en_async_o = 1'b1;
    ack_o      = 1'b0;
    gated_o    = 1'b0;
    busy_o     = 1'b0;
    case (state_q)
      StOn: begin
        ack_o = req_eff;
      end
      StWaitIdle: begin
        busy_o = 1'b1;
      end
      StGating: begin
        en_async_o = 1'b0;
        busy_o     = 1'b1;
      end
      StOff: begin
        en_async_o = 1'b0;
        gated_o    = 1'b1;
        ack_o      = ~req_eff;
      end
      StUngating: begin
        busy_o = 1'b1;
      end
      default: begin
        en_async_o = 1'b1;
      end
    endcase
  end

endmodule
